// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: state encodings, opcodes,
// datapath select codes, ALU/jump op codes and instruction-class decode helpers.
package mc_control_unit_pkg;

    typedef enum logic [2:0] {
        st_fetch  = 3'd0,
        st_decode = 3'd1,
        st_exec   = 3'd2,
        st_mem    = 3'd3,
        st_wb     = 3'd4,
        st_trap   = 3'd5
    } state_t;

    localparam logic [6:0] opc_op     = 7'b0110011;
    localparam logic [6:0] opc_op_imm = 7'b0010011;
    localparam logic [6:0] opc_lui    = 7'b0110111;
    localparam logic [6:0] opc_auipc  = 7'b0010111;
    localparam logic [6:0] opc_load   = 7'b0000011;
    localparam logic [6:0] opc_store  = 7'b0100011;
    localparam logic [6:0] opc_jal    = 7'b1101111;
    localparam logic [6:0] opc_jalr   = 7'b1100111;
    localparam logic [6:0] opc_branch = 7'b1100011;

    localparam logic       memaddr_pc      = 1'b0;
    localparam logic       memaddr_aluout  = 1'b1;
    localparam logic [1:0] pcsrc_alu       = 2'd0;
    localparam logic [1:0] pcsrc_aluout    = 2'd1;
    localparam logic [1:0] pcsrc_aluout_al = 2'd2;
    localparam logic [1:0] wb_aluout       = 2'd0;
    localparam logic [1:0] wb_mdr          = 2'd1;
    localparam logic [1:0] wb_pc4          = 2'd2;
    localparam logic [1:0] srca_pc         = 2'd0;
    localparam logic [1:0] srca_rs1        = 2'd1;
    localparam logic [1:0] srca_zero       = 2'd2;
    localparam logic [1:0] srcb_four       = 2'd0;
    localparam logic [1:0] srcb_rs2        = 2'd1;
    localparam logic [1:0] srcb_imm        = 2'd2;

    localparam logic [3:0] alu_add  = 4'd0;
    localparam logic [3:0] alu_sub  = 4'd1;
    localparam logic [3:0] alu_sll  = 4'd2;
    localparam logic [3:0] alu_slt  = 4'd3;
    localparam logic [3:0] alu_sltu = 4'd4;
    localparam logic [3:0] alu_xor  = 4'd5;
    localparam logic [3:0] alu_srl  = 4'd6;
    localparam logic [3:0] alu_sra  = 4'd7;
    localparam logic [3:0] alu_or   = 4'd8;
    localparam logic [3:0] alu_and  = 4'd9;
    localparam logic [3:0] alu_blt  = 4'd10;

    localparam logic [2:0] jump_none = 3'd0;
    localparam logic [2:0] jump_beq  = 3'd1;
    localparam logic [2:0] jump_bne  = 3'd2;
    localparam logic [2:0] jump_blt  = 3'd3;
    localparam logic [2:0] jump_bge  = 3'd4;
    localparam logic [2:0] jump_bltu = 3'd5;
    localparam logic [2:0] jump_bgeu = 3'd6;

    typedef enum logic [3:0] {
        cls_r, cls_i, cls_lui, cls_auipc, cls_load, cls_store,
        cls_jal, cls_jalr, cls_branch, cls_bad
    } iclass_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] aop;
        logic [2:0] jump;
    } ctrl_t;

    // Branch funct3 010/011 have no RV32I meaning and are treated as illegal.
    function automatic iclass_t classify(input logic [31:0] ir);
        case (ir[6:0])
            opc_op:     return cls_r;
            opc_op_imm: return cls_i;
            opc_lui:    return cls_lui;
            opc_auipc:  return cls_auipc;
            opc_load:   return cls_load;
            opc_store:  return cls_store;
            opc_jal:    return cls_jal;
            opc_jalr:   return cls_jalr;
            opc_branch: return (ir[14:13] == 2'b01) ? cls_bad : cls_branch;
            default:    return cls_bad;
        endcase
    endfunction

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? alu_sub : alu_add;
            3'b001:  return alu_sll;
            3'b010:  return alu_slt;
            3'b011:  return alu_sltu;
            3'b100:  return alu_xor;
            3'b101:  return alt ? alu_sra : alu_srl;
            3'b110:  return alu_or;
            default: return alu_and;
        endcase
    endfunction

    function automatic logic [2:0] jump_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return jump_beq;
            3'b001:  return jump_bne;
            3'b100:  return jump_blt;
            3'b101:  return jump_bge;
            3'b110:  return jump_bltu;
            3'b111:  return jump_bgeu;
            default: return jump_none;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_unit_imm_gen.sv
// Combinational immediate generator: decodes the I/S/B/U/J immediate from the
// instruction register according to its opcode.
module mc_control_unit_imm_gen
    import mc_control_unit_pkg::*;
(
    input  logic [31:0] ir,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        case (ir[6:0])
            opc_op_imm, opc_load, opc_jalr:
                imm = {{20{ir[31]}}, ir[31:20]};
            opc_store:
                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            opc_branch:
                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            opc_jal:
                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            opc_lui, opc_auipc:
                imm = {ir[31:12], 12'd0};
            default:
                imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb/trap) with registered control
// outputs. Optional retired-instruction counter enabled by macro RETIRE_CNT_EN.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter logic [2:0]  RESET_STATE  = 3'd0,
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    input  logic        Zero,
    output logic        MemReq,
    output logic        MemWe,
    output logic        MemAddrSel,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic        RegWrite,
    output logic [1:0]  WBSel,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  AOp,
    output logic [2:0]  jump,
    output logic [31:0] Imm,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic [2:0]  Funct3,
    output logic        IllegalInstr,
    output logic [2:0]  State
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] InstrRetired
`endif
);

    state_t      state, nxt;
    ctrl_t       ctrl, nxt_ctrl;
    iclass_t     cls;
    logic [31:0] ir;
    logic [31:0] wait_cnt;
    logic        taken, nxt_taken, illegal, wait_expired, waiting;
    logic [2:0]  f3;

    assign cls          = classify(ir);
    assign f3           = ir[14:12];
    assign nxt_taken    = (state == st_exec) ? Zero : taken;
    assign wait_expired = (MEM_WAIT_MAX != 0) && (wait_cnt == 32'(MEM_WAIT_MAX - 1));
    // The first FETCH cycle after reset has MemReq low, so it neither waits nor accepts data.
    assign waiting      = ((state == st_fetch && ctrl.mem_req) || state == st_mem) && !MemReady;

    mc_control_unit_imm_gen u_imm_gen (.ir(ir), .imm(Imm));

    always_comb begin
        nxt = state;
        case (state)
            st_fetch:  if (ctrl.mem_req) begin
                           if (MemReady)          nxt = st_decode;
                           else if (wait_expired) nxt = st_trap;
                       end
            st_decode: nxt = (cls == cls_bad) ? st_trap : st_exec;
            st_exec:   nxt = (cls == cls_load || cls == cls_store) ? st_mem : st_wb;
            st_mem:    if (MemReady)          nxt = st_wb;
                       else if (wait_expired) nxt = st_trap;
            st_wb:     nxt = st_fetch;
            default:   nxt = st_trap;
        endcase
    end

    // Control values for the state being entered, so outputs come straight from flops.
    always_comb begin
        nxt_ctrl = '0;
        case (nxt)
            st_fetch: begin
                nxt_ctrl.mem_req      = 1'b1;
                nxt_ctrl.mem_addr_sel = memaddr_pc;
            end
            st_exec: begin
                nxt_ctrl.src_a = srca_rs1;
                nxt_ctrl.src_b = srcb_imm;
                nxt_ctrl.aop   = alu_add;
                case (cls)
                    cls_r: begin
                        nxt_ctrl.src_b = srcb_rs2;
                        nxt_ctrl.aop   = alu_from_f3(f3, ir[30]);
                    end
                    cls_i:             nxt_ctrl.aop   = alu_from_f3(f3, ir[30] && f3 == 3'b101);
                    cls_lui:           nxt_ctrl.src_a = srca_zero;
                    cls_auipc, cls_jal: nxt_ctrl.src_a = srca_pc;
                    cls_branch: begin
                        nxt_ctrl.src_b = srcb_rs2;
                        nxt_ctrl.aop   = alu_blt;
                        nxt_ctrl.jump  = jump_from_f3(f3);
                    end
                    default: ;
                endcase
            end
            st_mem: begin
                nxt_ctrl.mem_req      = 1'b1;
                nxt_ctrl.mem_addr_sel = memaddr_aluout;
                nxt_ctrl.mem_we       = (cls == cls_store);
            end
            st_wb: begin
                nxt_ctrl.pc_write = 1'b1;
                nxt_ctrl.pc_src   = pcsrc_alu;
                nxt_ctrl.src_a    = srca_pc;
                nxt_ctrl.src_b    = srcb_four;
                case (cls)
                    cls_jal: begin
                        nxt_ctrl.reg_write = 1'b1;
                        nxt_ctrl.wb_sel    = wb_pc4;
                        nxt_ctrl.pc_src    = pcsrc_aluout;
                    end
                    cls_jalr: begin
                        nxt_ctrl.reg_write = 1'b1;
                        nxt_ctrl.wb_sel    = wb_pc4;
                        nxt_ctrl.pc_src    = pcsrc_aluout_al;
                    end
                    cls_branch: begin
                        nxt_ctrl.src_b = nxt_taken ? srcb_imm : srcb_four;
                        nxt_ctrl.jump  = jump_from_f3(f3);
                    end
                    cls_store: ;
                    cls_load: begin
                        nxt_ctrl.reg_write = 1'b1;
                        nxt_ctrl.wb_sel    = wb_mdr;
                    end
                    default: begin
                        nxt_ctrl.reg_write = 1'b1;
                        nxt_ctrl.wb_sel    = wb_aluout;
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= state_t'(RESET_STATE);
            ctrl     <= '0;
            ir       <= 32'd0;
            taken    <= 1'b0;
            illegal  <= 1'b0;
            wait_cnt <= 32'd0;
`ifdef RETIRE_CNT_EN
            InstrRetired <= 32'd0;
`endif
        end else begin
            state    <= nxt;
            ctrl     <= nxt_ctrl;
            taken    <= nxt_taken;
            wait_cnt <= waiting ? wait_cnt + 32'd1 : 32'd0;
            if (state == st_fetch && ctrl.mem_req && MemReady)
                ir <= MemRData;
            if (nxt == st_trap)
                illegal <= 1'b1;
`ifdef RETIRE_CNT_EN
            if (state == st_wb)
                InstrRetired <= InstrRetired + 32'd1;
`endif
        end
    end

    assign MemReq       = ctrl.mem_req;
    assign MemWe        = ctrl.mem_we;
    assign MemAddrSel   = ctrl.mem_addr_sel;
    assign PCWrite      = ctrl.pc_write;
    assign PCSrc        = ctrl.pc_src;
    assign RegWrite     = ctrl.reg_write;
    assign WBSel        = ctrl.wb_sel;
    assign ALUSrcA      = ctrl.src_a;
    assign ALUSrcB      = ctrl.src_b;
    assign AOp          = ctrl.aop;
    assign jump         = ctrl.jump;
    assign Rs1          = ir[19:15];
    assign Rs2          = ir[24:20];
    assign Rd           = ir[11:7];
    assign Funct3       = ir[14:12];
    assign IllegalInstr = illegal;
    assign State        = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed instruction cases plus random instruction stream,
// checked cycle by cycle against an instruction-level model and an expected-state queue.
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    localparam int WAIT_MAX = 16;

    logic        CLK, Reset, MemReady, Zero;
    logic [31:0] MemRData;
    logic        MemReq, MemWe, MemAddrSel, PCWrite, RegWrite, IllegalInstr;
    logic [1:0]  PCSrc, WBSel, ALUSrcA, ALUSrcB;
    logic [3:0]  AOp;
    logic [2:0]  jump, Funct3, State;
    logic [31:0] Imm;
    logic [4:0]  Rs1, Rs2, Rd;
`ifdef RETIRE_CNT_EN
    logic [31:0] InstrRetired;
`endif

    mc_control_unit #(.RESET_STATE(3'd0), .MEM_WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .Reset(Reset), .MemRData(MemRData), .MemReady(MemReady), .Zero(Zero),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddrSel(MemAddrSel), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .WBSel(WBSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .AOp(AOp), .jump(jump), .Imm(Imm), .Rs1(Rs1), .Rs2(Rs2),
        .Rd(Rd), .Funct3(Funct3), .IllegalInstr(IllegalInstr), .State(State)
`ifdef RETIRE_CNT_EN
        , .InstrRetired(InstrRetired)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int exp_retired = 0;
    logic [2:0] exp_q[$];

    typedef struct packed {
        logic        bad, is_mem, store, branch, link, wb_rw, chk_imm;
        logic [1:0]  a, b, wb_sel, pc_src;
        logic [3:0]  aop;
        logic [2:0]  jmp;
        logic [31:0] imm;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    // Instruction-level reference: what each RV32I instruction should make the unit drive.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [3:0]  ops [8];
        logic [2:0]  jt [8];
        logic [31:0] sx;
        logic [2:0]  f3;
        ops = '{alu_add, alu_sll, alu_slt, alu_sltu, alu_xor, alu_srl, alu_or, alu_and};
        jt  = '{jump_beq, jump_bne, jump_none, jump_none, jump_blt, jump_bge, jump_bltu, jump_bgeu};
        f3  = w[14:12];
        sx  = w[31] ? 32'hFFFF_FFFF : 32'h0;
        e = '0;
        e.a = 2'd1; e.b = 2'd2; e.aop = alu_add; e.wb_rw = 1'b1; e.chk_imm = 1'b1;
        e.imm = (sx << 11) | 32'(w[30:20]);
        case (w[6:0])
            7'h33: begin
                e.b = 2'd1; e.chk_imm = 1'b0; e.aop = ops[f3];
                if (w[30] && f3 == 3'd0) e.aop = alu_sub;
                if (w[30] && f3 == 3'd5) e.aop = alu_sra;
            end
            7'h13: begin
                e.aop = ops[f3];
                if (w[30] && f3 == 3'd5) e.aop = alu_sra;
            end
            7'h37: begin e.a = 2'd2; e.imm = w & 32'hFFFF_F000; end
            7'h17: begin e.a = 2'd0; e.imm = w & 32'hFFFF_F000; end
            7'h03: begin e.is_mem = 1'b1; e.wb_sel = 2'd1; end
            7'h23: begin
                e.is_mem = 1'b1; e.store = 1'b1; e.wb_rw = 1'b0;
                e.imm = (sx << 11) | (32'(w[30:25]) << 5) | 32'(w[11:7]);
            end
            7'h6f: begin
                e.a = 2'd0; e.link = 1'b1; e.wb_sel = 2'd2; e.pc_src = 2'd1;
                e.imm = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            7'h67: begin e.link = 1'b1; e.wb_sel = 2'd2; e.pc_src = 2'd2; end
            7'h63: begin
                e.b = 2'd1; e.aop = alu_blt; e.branch = 1'b1; e.wb_rw = 1'b0; e.jmp = jt[f3];
                e.bad = (f3 == 3'd2 || f3 == 3'd3);
                e.imm = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            default: e.bad = 1'b1;
        endcase
        return e;
    endfunction

    // Runs one instruction: fw / mw low-ready cycles in FETCH / MEM (>= WAIT_MAX means time out).
    task automatic run_instr(input logic [31:0] w, input int fw, input int mw, input logic z,
                             output logic trapped);
        exp_t e;
        logic [2:0] s;
        int fk, mk;
        e = model(w);
        fk = 0; mk = 0; trapped = 1'b0;
        exp_q.delete();
        for (int i = 0; i < fw && i < WAIT_MAX; i++) exp_q.push_back(3'd0);
        if (fw >= WAIT_MAX) repeat (3) exp_q.push_back(3'd5);
        else begin
            exp_q.push_back(3'd0);
            exp_q.push_back(3'd1);
            if (e.bad) repeat (3) exp_q.push_back(3'd5);
            else begin
                exp_q.push_back(3'd2);
                if (e.is_mem) begin
                    for (int i = 0; i < mw && i < WAIT_MAX; i++) exp_q.push_back(3'd3);
                    if (mw >= WAIT_MAX) repeat (3) exp_q.push_back(3'd5);
                    else exp_q.push_back(3'd3);
                end
                if (!(e.is_mem && mw >= WAIT_MAX)) exp_q.push_back(3'd4);
            end
        end
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            s = exp_q.pop_front();
            check("state", State, s);
            Zero = 1'($urandom_range(0, 1));
            MemReady = 1'b0;
            MemRData = $urandom;
            case (s)
                3'd0: begin
                    check("fetch_req", MemReq, 1'b1);
                    check("fetch_addrsel", MemAddrSel, 1'b0);
                    check("fetch_we", MemWe, 1'b0);
                    check("fetch_illegal", IllegalInstr, 1'b0);
`ifdef RETIRE_CNT_EN
                    if (fk == 0) check("retired", InstrRetired, exp_retired);
`endif
                    MemReady = (fk == fw);
                    MemRData = w;
                    fk++;
                end
                3'd1: begin
                    check("decode_strobes", {MemReq, PCWrite, RegWrite, MemWe}, 4'b0);
                end
                3'd2: begin
                    check("exec_a", ALUSrcA, e.a);
                    check("exec_b", ALUSrcB, e.b);
                    check("exec_aop", AOp, e.aop);
                    if (e.chk_imm) check("exec_imm", Imm, e.imm);
                    if (e.branch) check("exec_jump", jump, e.jmp);
                    check("exec_fields", {Rs1, Rs2, Rd, Funct3}, {w[19:15], w[24:20], w[11:7], w[14:12]});
                    check("exec_strobes", {MemReq, PCWrite, RegWrite}, 3'b0);
                    Zero = z;
                end
                3'd3: begin
                    check("mem_req", MemReq, 1'b1);
                    check("mem_addrsel", MemAddrSel, 1'b1);
                    check("mem_we", MemWe, e.store);
                    if (e.store) check("mem_imm", Imm, e.imm);
                    MemReady = (mk == mw);
                    mk++;
                end
                3'd4: begin
                    check("wb_regwrite", RegWrite, e.wb_rw);
                    check("wb_pcwrite", PCWrite, 1'b1);
                    check("wb_pcsrc", PCSrc, e.pc_src);
                    check("wb_memreq", MemReq, 1'b0);
                    if (e.wb_rw) check("wb_sel", WBSel, e.wb_sel);
                    if (e.link) check("wb_rd", Rd, w[11:7]);
                    else begin
                        check("wb_a", ALUSrcA, 2'd0);
                        check("wb_b", ALUSrcB, (e.branch && z) ? 2'd2 : 2'd0);
                        check("wb_aop", AOp, alu_add);
                    end
                    if (e.branch) check("wb_jump", jump, e.jmp);
                    exp_retired++;
                end
                default: begin
                    check("trap_illegal", IllegalInstr, 1'b1);
                    check("trap_strobes", {MemReq, MemWe, PCWrite, RegWrite}, 4'b0);
                    trapped = 1'b1;
                end
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1'b1;
        MemReady = 1'($urandom_range(0, 1));
        @(negedge CLK);
        check("rst_state", State, 3'd0);
        check("rst_strobes", {MemReq, MemWe, PCWrite, RegWrite}, 4'b0);
        check("rst_illegal", IllegalInstr, 1'b0);
`ifdef RETIRE_CNT_EN
        check("rst_retired", InstrRetired, 32'd0);
`endif
        Reset = 1'b0;
        MemReady = 1'($urandom_range(0, 1));
        exp_retired = 0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic tr;
        logic [31:0] w;
        logic [6:0] opcs [10];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6f, 7'h67, 7'h63, 7'h7f};
        Reset = 1'b1; MemReady = 1'b0; Zero = 1'b0; MemRData = 32'd0;
        do_reset();

        run_instr(32'h0050_0093, 0, 0, 1'b0, tr);   // addi x1,x0,5
        run_instr(32'h0020_8463, 0, 0, 1'b1, tr);   // beq taken
        run_instr(32'h0020_8463, 0, 0, 1'b0, tr);   // beq not taken
        run_instr(32'h0040_A183, 0, 3, 1'b0, tr);   // lw with 3 stall cycles
        run_instr(32'h0030_A423, 1, 0, 1'b0, tr);   // sw
        run_instr(32'h0100_00EF, 0, 0, 1'b0, tr);   // jal x1,16
        run_instr(32'h0000_8067, 2, 0, 1'b0, tr);   // jalr x0,0(x1)
        run_instr(32'h0050_0093, WAIT_MAX - 1, 0, 1'b0, tr);
        run_instr(32'h0040_A183, 0, WAIT_MAX - 1, 1'b0, tr);

        run_instr(32'h0000_0000, 0, 0, 1'b0, tr);   // illegal opcode
        check("illegal_trapped", tr, 1'b1);
        do_reset();

        run_instr(32'h0050_0093, WAIT_MAX, 0, 1'b0, tr);   // fetch timeout
        check("fetch_timeout", tr, 1'b1);
        do_reset();
        run_instr(32'h0040_A183, 0, WAIT_MAX, 1'b0, tr);   // mem timeout
        check("mem_timeout", tr, 1'b1);
        do_reset();

        // reset during a fetch wait
        repeat (2) begin
            @(negedge CLK);
            check("fw_req", MemReq, 1'b1);
            MemReady = 1'b0;
        end
        do_reset();

        for (int n = 0; n < 300; n++) begin
            w = $urandom;
            w[6:0] = opcs[$urandom_range(0, 9)];
            run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), tr);
            if (tr) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
